byte_decrypt_engine: RTL and testbench

BYTE_DECRYPT_ENGINE -- requirements
Module: byte_decrypt_engine

---
 rtl/byte_decrypt_engine.sv | 94 +++++++++
 tb/tb_byte_decrypt_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/byte_decrypt_engine.sv
// Byte decryptor: undoes cipher = rotl(plain ^ key, n) by rotating right one bit per
// cycle, then XOR-ing the key, with a valid/ready handshake on both sides.
module byte_decrypt_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  cipher_in,
    input  logic [7:0]  key,
    input  logic [2:0]  shift_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  plain_out,
    output logic        busy,
    output logic [15:0] byte_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  key_q, key_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] count_q, count_d;

    function automatic logic [7:0] rotr1(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            key_q   <= 8'h00;
            cnt_q   <= 3'd0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = cipher_in;
                    key_d   = key;
                    cnt_d   = shift_amt;
                    state_d = (shift_amt != 3'd0) ? ROT : FIN;
                end
            end
            ROT: begin
                data_d = rotr1(data_q);
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                data_d  = data_q ^ key_q;
                state_d = OUT;
            end
            OUT: begin
                // Counter wraps naturally at 16 bits.
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign plain_out  = out_valid ? data_q : 8'h00;
    assign byte_count = count_q;

endmodule

// File: tb/tb_byte_decrypt_engine.sv
// Self-checking bench for byte_decrypt_engine: directed vectors plus random bytes
// compared against an arithmetic rotate-right/XOR reference model.
module tb_byte_decrypt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  cipher_in;
    logic [7:0]  key;
    logic [2:0]  shift_amt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  plain_out;
    logic        busy;
    logic [15:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    byte_decrypt_engine dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cipher_in  (cipher_in),
        .key        (key),
        .shift_amt  (shift_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plain_out  (plain_out),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: undo rotl by rotating right with integer shifts, then remove the key.
    function automatic logic [7:0] model(input int c, input int k, input int s);
        int r;
        r = ((c >> s) | (c << (8 - s))) & 255;
        r = r ^ k;
        return r[7:0];
    endfunction

    task automatic send(input logic [7:0] c, input logic [7:0] k, input logic [2:0] s,
                        input int stall, input bit chg, input bit hold_new);
        logic [7:0] exp_p;
        int lat;
        exp_p = model(int'(c), int'(k), int'(s));
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1'b1);
        in_valid  = 1'b1;
        cipher_in = c;
        key       = k;
        shift_amt = s;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chg) begin
            key       = 8'h00;
            shift_amt = 3'd5;
            cipher_in = 8'hFF;
        end
        if (hold_new) begin
            in_valid  = 1'b1;
            cipher_in = 8'h11;
            key       = 8'h22;
            shift_amt = 3'd1;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            check_eq("plain_zero_idle", plain_out, 8'h00);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, int'(s) + 1);
        check_eq("plain_out", plain_out, exp_p);
        check_eq("count_before", byte_count, exp_cnt[15:0]);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", out_valid, 1'b1);
            check_eq("stall_plain", plain_out, exp_p);
            check_eq("stall_in_ready", in_ready, 1'b0);
            check_eq("stall_count", byte_count, exp_cnt[15:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        check_eq("count_after", byte_count, exp_cnt[15:0]);
        check_eq("valid_dropped", out_valid, 1'b0);
        check_eq("busy_idle", busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        cipher_in = 8'h00;
        key       = 8'h00;
        shift_amt = 3'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_plain", plain_out, 8'h00);
        check_eq("rst_count", byte_count, 16'h0000);
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1'b1);

        // Directed vectors, then backpressure with a new byte held on the input.
        send(8'hCC, 8'h3C, 3'd3, 0, 1'b0, 1'b0);
        send(8'h5A, 8'hFF, 3'd0, 0, 1'b0, 1'b0);
        send(8'h01, 8'h00, 3'd7, 0, 1'b0, 1'b0);
        send(8'hCC, 8'h3C, 3'd3, 5, 1'b0, 1'b1);
        send(8'h11, 8'h22, 3'd1, 0, 1'b0, 1'b0);
        send(8'hCC, 8'h3C, 3'd3, 0, 1'b1, 1'b0);

        // Reset while in ROT with two rotations remaining.
        @(negedge clk);
        in_valid  = 1'b1;
        cipher_in = 8'hCC;
        key       = 8'h3C;
        shift_amt = 3'd3;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rot_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_out_valid", out_valid, 1'b0);
        check_eq("async_busy", busy, 1'b0);
        check_eq("async_plain", plain_out, 8'h00);
        check_eq("async_count", byte_count, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        check_eq("post_rst_in_ready", in_ready, 1'b1);

        // First accept on the first rising edge after release, then random traffic.
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 0,
                 1'($urandom_range(0, 1)), 1'b0);
        end
        check_eq("final_count", byte_count, 16'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
